// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch front end.
package fetch_pkg;
  localparam logic [1:0] KIND_BRANCH = 2'b00;
  localparam logic [1:0] KIND_JUMP = 2'b01;
  localparam logic [1:0] KIND_JR = 2'b10;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int QDEPTH = 2;
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_DROP} fetch_state_t;
endpackage

// File: rtl/instr_queue.sv
// instr_queue: 2-entry {instr, pc} FIFO with a registered head and synchronous flush.
module instr_queue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic [1:0]  count
);
  logic [63:0] mem_q [2];
  logic [63:0] mem_d [2];
  logic rd_q, rd_d, wr_q, wr_d, pop_ok;
  logic [1:0] cnt_q, cnt_d;
  always_comb begin
    pop_ok = pop && cnt_q != 2'd0;
    mem_d = mem_q;
    if (push && !flush) mem_d[wr_q] = wdata;
    rd_d = flush ? 1'b0 : rd_q ^ pop_ok;
    wr_d = flush ? 1'b0 : wr_q ^ push;
    cnt_d = flush ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop_ok};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner issuing req/ack word fetches into a 2-entry queue,
// with branch/jump/jr redirects that flush the queue and drop wrong-path fetches.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_kind,
  input  logic [31:0] redirect_pc,
  input  logic [15:0] redirect_imm16,
  input  logic [25:0] redirect_target26,
  input  logic [31:0] redirect_reg,
  output logic        err_misaligned
);
  fetch_state_t state_q, state_d, after_ack;
  logic [31:0] pc_q, pc_d, hold_q, hold_d;
  logic err_q, err_d, push, pop, ack_done;
  logic [1:0] count;
  logic [2:0] occ_next;
  logic [63:0] head;
  function automatic logic [31:0] calc_target(input logic [1:0] kind, input logic [31:0] pc,
                                              input logic [15:0] imm, input logic [25:0] t26,
                                              input logic [31:0] rs);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    return kind == KIND_BRANCH ? pc4 + {{14{imm[15]}}, imm, 2'b00} :
           kind == KIND_JR ? {rs[31:2], 2'b00} : {pc4[31:28], t26, 2'b00};
  endfunction
  always_comb begin
    push = state_q == F_REQ && imem_ack && !redirect_valid;
    pop = instr_ready && !redirect_valid && count != 2'd0;
    occ_next = redirect_valid ? 3'd0 : {1'b0, count} + {2'b0, push} - {2'b0, pop};
    pc_d = redirect_valid ? calc_target(redirect_kind, redirect_pc, redirect_imm16,
                                        redirect_target26, redirect_reg) :
           push ? pc_q + 32'd4 : pc_q;
    // A dropped fetch must keep presenting the address it was issued with.
    hold_d = state_q == F_REQ ? pc_q : hold_q;
    err_d = err_q | (redirect_valid && redirect_kind == KIND_JR && redirect_reg[1:0] != 2'b00);
    ack_done = imem_ack && state_q != F_IDLE;
    after_ack = occ_next < 3'(QDEPTH) ? F_REQ : F_IDLE;
    state_d = (state_q == F_IDLE || ack_done) ? after_ack :
              (state_q == F_REQ && redirect_valid) ? F_DROP : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= F_IDLE;
      pc_q <= {RESET_PC[31:2], 2'b00};
      hold_q <= 32'd0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      hold_q <= hold_d;
      err_q <= err_d;
    end
  end
  instr_queue u_queue (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .wdata({imem_rdata, pc_q}),
    .rdata(head),
    .count(count)
  );
  assign imem_req = state_q != F_IDLE;
  assign imem_addr = state_q == F_DROP ? hold_q : pc_q;
  assign instr_valid = count != 2'd0;
  assign {instr, instr_pc} = head;
  assign err_misaligned = err_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed tests of fetch sequencing, backpressure, redirects and reset.
module tb_instruction_fetch;
  logic clk, rst_n, imem_req, imem_ack, instr_valid, instr_ready, redirect_valid, err_misaligned;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc, redirect_reg;
  logic [1:0] redirect_kind;
  logic [15:0] redirect_imm16;
  logic [25:0] redirect_target26;
  int checks = 0;
  int errors = 0;
  int wait_n = 1;
  int wcnt = 0;
  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_kind(redirect_kind),
    .redirect_pc(redirect_pc), .redirect_imm16(redirect_imm16),
    .redirect_target26(redirect_target26), .redirect_reg(redirect_reg),
    .err_misaligned(err_misaligned)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Memory acks after wait_n cycles of held request; data is address-tagged.
  always_ff @(posedge clk) wcnt <= (!imem_req || imem_ack) ? 0 : wcnt + 1;
  assign imem_ack = imem_req && wcnt >= wait_n;
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  task automatic do_reset;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_idle;
    wait_n = 1;
    instr_ready = 1'b0;
    do_reset;
    repeat (10) @(negedge clk);
  endtask

  task automatic pulse_redirect(input logic [1:0] kind, input logic [31:0] pc,
                                input logic [15:0] imm, input logic [25:0] t26,
                                input logic [31:0] rs);
    redirect_kind = kind;
    redirect_pc = pc;
    redirect_imm16 = imm;
    redirect_target26 = t26;
    redirect_reg = rs;
    redirect_valid = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    instr_ready = 1'b1;
    wait_n = 1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || err_misaligned !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: req=%b valid=%b err=%b, want 0 0 0", imem_req, instr_valid, err_misaligned);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h valid=%b, want 1 00000000 0", imem_req, imem_addr, instr_valid);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_valid: valid=%b, want 0", instr_valid);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'hA5A5_0000) begin
      errors++;
      $display("FAIL first_instr: valid=%b pc=%h instr=%h, want 1 00000000 a5a50000", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_stream;
    int seen = 0;
    logic [31:0] exp_pc;
    for (int i = 0; i < 40 && seen < 2; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        exp_pc = 32'h4 + 32'(seen) * 32'h4;
        checks++;
        if (instr_pc !== exp_pc || instr !== (exp_pc ^ 32'hA5A5_0000)) begin
          errors++;
          $display("FAIL stream_%0d: pc=%h instr=%h, want %h %h", seen, instr_pc, instr, exp_pc, exp_pc ^ 32'hA5A5_0000);
        end
        seen++;
      end
    end
    checks++;
    if (seen != 2) begin
      errors++;
      $display("FAIL stream_timeout: got %0d words, want 2", seen);
    end
  endtask

  task automatic test_backpressure;
    wait_n = 1;
    instr_ready = 1'b0;
    do_reset;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 6) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'hA5A5_0000 || imem_req !== 1'b0) begin
          errors++;
          $display("FAIL full_hold_%0d: valid=%b pc=%h instr=%h req=%b, want 1 00000000 a5a50000 0",
                   i, instr_valid, instr_pc, instr, imem_req);
        end
      end
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_pc !== 32'h4) begin
      errors++;
      $display("FAIL release: req=%b addr=%h head_pc=%h, want 1 00000008 00000004", imem_req, imem_addr, instr_pc);
    end
  endtask

  task automatic test_branch;
    fill_idle;
    pulse_redirect(2'b00, 32'h100, 16'hFFFE, 26'h0, 32'h0);
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFC) begin
      errors++;
      $display("FAIL branch_target: valid=%b req=%b addr=%h, want 0 1 000000fc", instr_valid, imem_req, imem_addr);
    end
    for (int i = 0; i < 10 && !instr_valid; i++) @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'hFC || instr !== (32'hFC ^ 32'hA5A5_0000)) begin
      errors++;
      $display("FAIL branch_word: valid=%b pc=%h instr=%h, want 1 000000fc a5a500fc", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_jump_jr;
    fill_idle;
    pulse_redirect(2'b01, 32'hF000_0010, 16'h0, 26'h0000_040, 32'h0);
    checks++;
    if (imem_addr !== 32'hF000_0100 || imem_req !== 1'b1 || err_misaligned !== 1'b0) begin
      errors++;
      $display("FAIL jump_target: addr=%h req=%b err=%b, want f0000100 1 0", imem_addr, imem_req, err_misaligned);
    end
    fill_idle;
    pulse_redirect(2'b10, 32'h0, 16'h0, 26'h0, 32'h0000_2003);
    checks++;
    if (imem_addr !== 32'h2000 || imem_req !== 1'b1 || err_misaligned !== 1'b1) begin
      errors++;
      $display("FAIL jr_target: addr=%h req=%b err=%b, want 00002000 1 1", imem_addr, imem_req, err_misaligned);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (err_misaligned !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b, want 1", err_misaligned);
    end
  endtask

  task automatic test_drop_in_flight;
    bit found = 0;
    int n = 0;
    wait_n = 3;
    instr_ready = 1'b1;
    do_reset;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      found = imem_req && imem_addr == 32'h8;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL drop_setup: fetch of 00000008 never issued");
    end
    pulse_redirect(2'b00, 32'h100, 16'h0010, 26'h0, 32'h0);
    while (!imem_ack && n < 10) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL drop_hold_%0d: req=%b addr=%h valid=%b, want 1 00000008 0", n, imem_req, imem_addr, instr_valid);
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (imem_ack !== 1'b1 || imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL drop_ack: ack=%b addr=%h, want 1 00000008", imem_ack, imem_addr);
    end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h144 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_retarget: req=%b addr=%h valid=%b, want 1 00000144 0", imem_req, imem_addr, instr_valid);
    end
    for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h144 || instr !== (32'h144 ^ 32'hA5A5_0000)) begin
      errors++;
      $display("FAIL drop_target_word: valid=%b pc=%h instr=%h, want 1 00000144 a5a50144", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_async_reset;
    wait_n = 3;
    instr_ready = 1'b0;
    do_reset;
    repeat (20) @(negedge clk);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b1 || instr_pc !== 32'h4) begin
      errors++;
      $display("FAIL arst_setup: req=%b addr=%h valid=%b pc=%h, want 1 00000008 1 00000004",
               imem_req, imem_addr, instr_valid, instr_pc);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_async: req=%b valid=%b, want 0 0", imem_req, instr_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst_restart: req=%b addr=%h valid=%b, want 1 00000000 0", imem_req, imem_addr, instr_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_kind = 2'b00;
    redirect_pc = 32'h0;
    redirect_imm16 = 16'h0;
    redirect_target26 = 26'h0;
    redirect_reg = 32'h0;
    test_reset;
    test_stream;
    test_backpressure;
    test_branch;
    test_jump_jr;
    test_drop_in_flight;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
